seq_shift_unit: RTL
===================

Name: seq_shift_unit

Overview:
Parametrised, multi-cycle shift unit. It generalises the datapath's single-cycle 8-bit left/right shifter to W bits, adds four shift modes and a carry-out, and iterates STEP bit positions per clock under a start/done handshake. It sits beside the ALU. The controller pulses Start, waits on Busy/Done, then reads Result/Carry.

Parameters:
W, 8, data width in bits (>= 2).
SHW, 4, shift-amount width; Shamt range 0..2^SHW-1. Values >= W are legal.
STEP, 1, maximum bit positions shifted per clock; power of 2, 1 <= STEP <= W.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request; accepted only in IDLE or DONE.
Source  input  W  operand, sampled on acceptance.
Shamt  input  SHW  shift amount, sampled on acceptance.
Mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL (rotate left); sampled on acceptance.
Busy  output  1  high while state is SHIFT or DONE.
Done  output  1  one-cycle pulse; Result/Carry are valid while it is high.
Result  output  W  shifted value; driven directly from the working register.
Carry  output  1  last bit shifted out (ROL: last bit wrapped into bit 0).

Behaviour:
- Reset, asynchronous and immediate, including mid-operation: state=IDLE, Busy=0, Done=0, Result=0, Carry=0, remaining count=0. Any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE. Busy = (state != IDLE). Done = (state == DONE).
- Acceptance: a rising edge with Start=1 while in IDLE or DONE.
  - Working register <- Source; rem <- Shamt; mode latched; Carry <- 0.
  - Next state is DONE if Shamt == 0, otherwise SHIFT.
  - Acceptance in DONE gives back-to-back operation; Done still pulses for the finished operation.
- Start is ignored in SHIFT; latched operands do not change.
- SHIFT, each edge:
  - k = min(STEP, rem); shift the working register by k per Mode; rem <- rem - k.
  - Carry <- the last bit to leave, i.e. the bit nearest the vacated end among the k bits shifted out.
  - Next state is DONE when the new rem == 0.
- Per-mode rules:
  - LSL: shift left, zero fill; Carry = bit W-k of the pre-step value.
  - LSR: shift right, zero fill; Carry = bit k-1.
  - ASR: shift right, fill with the sign bit of the pre-step value; Carry = bit k-1.
  - ROL: rotate left; Carry = new bit 0.
- Shamt >= W:
  - Iteration continues to the full count; no clamping logic is needed.
  - LSL/LSR give 0 with Carry 0 once past W. ASR gives all sign bits with Carry = sign. ROL is effectively Shamt mod W.
- DONE: lasts exactly one cycle. Without a new Start the next state is IDLE.
- Result/Carry hold their value in IDLE until the next acceptance.
- Latency: Done is high in the cycle beginning 1 + ceil(Shamt/STEP) edges after the accepting edge.
  - Shamt=0 gives 1 cycle; Result = Source, Carry = 0.
- Arithmetic: rem is SHW bits and never underflows. All shifts stay within W bits; bits shifted out are discarded except the one captured in Carry.

Test Plan:
1. W=8, STEP=1: LSL, Source=0x96, Shamt=3 -> Busy high for 4 cycles; Done 4 edges after accept; Result=0xB0, Carry=0; intermediate Carry after step 1 = 1.
2. ASR, Source=0x96, Shamt=7 -> Result=0xFF, Carry=0, Done at edge 8. Then LSL, Source=0xFF, Shamt=9 -> Result=0x00, Carry=0, Done at edge 10.
3. ROL, Source=0x81, Shamt=1 -> Result=0x03, Carry=1. Then, accepted in the DONE cycle, LSR, Source=0x81, Shamt=0 -> Done 1 edge later; Result=0x81, Carry=0.
4. STEP=2: LSR, Source=0xF0, Shamt=5 -> steps of 2, 2, 1; Result=0x07, Carry=1, Done 4 edges after accept.
5. Start with Source=0x55 asserted during SHIFT of LSL 0x01, Shamt=6 -> ignored; Result=0x40. Reset asserted mid-SHIFT, between clock edges -> Busy, Done, Result, Carry all 0 before the next edge; a new Start after deassertion operates normally.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROL shifter: up to STEP positions per clock, Done pulses 1+ceil(Shamt/STEP) edges after accept.
// Start is only taken in IDLE or DONE and is ignored while shifting; Result/Carry hold until the next acceptance.
module seq_shift_unit #(
  parameter int W    = 8,
  parameter int SHW  = 4,
  parameter int STEP = 1
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Start,
  input  logic [W-1:0]   Source,
  input  logic [SHW-1:0] Shamt,
  input  logic [1:0]     Mode,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Result,
  output logic           Carry
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;

  state_t         state_q, state_d;
  logic [W-1:0]   work_q, work_d;
  logic [SHW-1:0] rem_q, rem_d;
  logic [1:0]     mode_q, mode_d;
  logic           carry_q, carry_d;

  logic [SHW-1:0] k;
  logic [W-1:0]   shifted;
  logic [W-1:0]   pre_l, pre_r;
  logic           cout;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  // k = min(STEP, rem); shifting by k-1 first exposes the last bit to leave at the register edge.
  always_comb begin
    k       = (int'(rem_q) < STEP) ? rem_q : SHW'(STEP);
    pre_l   = work_q << (k - SHW'(1));
    pre_r   = work_q >> (k - SHW'(1));
    shifted = work_q;
    cout    = 1'b0;
    case (mode_q)
      M_LSL: begin
        shifted = work_q << k;
        cout    = pre_l[W-1];
      end
      M_LSR: begin
        shifted = work_q >> k;
        cout    = pre_r[0];
      end
      M_ASR: begin
        shifted = W'($signed(work_q) >>> k);
        cout    = pre_r[0];
      end
      default: begin
        shifted = (work_q << k) | (work_q >> (W - int'(k)));
        cout    = shifted[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    case (state_q)
      S_SHIFT: begin
        work_d  = shifted;
        carry_d = cout;
        rem_d   = rem_q - k;
        state_d = (rem_q == k) ? S_DONE : S_SHIFT;
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (Start) begin
          work_d  = Source;
          rem_d   = Shamt;
          mode_d  = Mode;
          carry_d = 1'b0;
          state_d = (Shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
    endcase
  end

  assign Busy   = (state_q != S_IDLE);
  assign Done   = (state_q == S_DONE);
  assign Result = work_q;
  assign Carry  = carry_q;

endmodule
